// File: rtl/joy_db15_pkg.sv
`default_nettype none
// ============================================================================
// Module      : joy_db15_pkg
// Description : Shared constants and types for the DB15 serial joystick link.
//               Bit positions match the reader side (joy_db15).
// Revision    : 1.0 - initial release
// ============================================================================
package joy_db15_pkg;

    localparam int FRAME_BITS_DEFAULT = 24;
    localparam int JOY_BITS           = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Serial bit positions within one joystick word
    localparam int RIGHT = 0;
    localparam int LEFT  = 1;
    localparam int DOWN  = 2;
    localparam int UP    = 3;
    localparam int B1    = 4;
    localparam int B2    = 5;
    localparam int B3    = 6;
    localparam int B4    = 7;
    localparam int B5    = 8;
    localparam int B6    = 9;
    localparam int B7    = 10;
    localparam int B8    = 11;

endpackage
`default_nettype wire

// File: rtl/joy_db15_tx_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge
// Description : Multi-flop synchroniser for an asynchronous pin followed by a
//               registered edge detector. level, rise and fall are mutually
//               aligned: all three describe the same synchronised sample.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic Reset_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;

    // Synchroniser chain plus edge register; idles high out of reset so a
    // low pin after reset is seen as a falling edge.
    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            r_sync <= '1;
            level  <= 1'b1;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
            level  <= r_sync[SYNC_STAGES-1];
            rise   <= r_sync[SYNC_STAGES-1] & ~level;
            fall   <= ~r_sync[SYNC_STAGES-1] & level;
        end
    end

endmodule
`default_nettype wire

// File: rtl/joy_db15_tx.sv
`default_nettype none
// ============================================================================
// Module      : joy_db15_tx
// Description : DB15 joystick adapter emulation. Latches two joystick words
//               on JOY_LOAD (active-low, transparent while low) and shifts
//               them out active-low on JOY_DATA, one bit per JOY_CLK rise.
// Revision    : 1.0 - initial release
// ============================================================================
module joy_db15_tx
    import joy_db15_pkg::*;
#(
    parameter int FRAME_BITS  = FRAME_BITS_DEFAULT,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 48000
) (
    input  logic                clk,
    input  logic                Reset_n,
    input  logic [JOY_BITS-1:0] joystick1,
    input  logic [JOY_BITS-1:0] joystick2,
    input  logic                JOY_CLK,
    input  logic                JOY_LOAD,
    output logic                JOY_DATA,
    output logic                frame_done,
    output logic                link_active
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    state_t                  r_state;
    logic [FRAME_BITS-1:0]   r_shift;
    logic [CNT_W-1:0]        r_bit_cnt;
    logic [TO_W-1:0]         r_to_cnt;

    logic                    w_clk_level;
    logic                    w_clk_rise;
    logic                    w_clk_fall;
    logic                    w_load_level;
    logic                    w_load_rise;
    logic                    w_load_fall;
    logic                    w_load_low;
    logic [FRAME_BITS-1:0]   w_load_word;
    logic                    w_unused;

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_clk (
        .clk      (clk),
        .Reset_n  (Reset_n),
        .async_in (JOY_CLK),
        .level    (w_clk_level),
        .rise     (w_clk_rise),
        .fall     (w_clk_fall)
    );

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_load (
        .clk      (clk),
        .Reset_n  (Reset_n),
        .async_in (JOY_LOAD),
        .level    (w_load_level),
        .rise     (w_load_rise),
        .fall     (w_load_fall)
    );

    assign w_load_low  = ~w_load_level;
    assign w_load_word = FRAME_BITS'({~joystick2, ~joystick1});
    assign w_unused    = ^{w_clk_level, w_clk_fall, w_load_rise};

    // Frame FSM: load has priority over everything, so a load that coincides
    // with a clock rise discards the shift, and a load mid-frame aborts it.
    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            r_state    <= IDLE;
            r_shift    <= '1;
            r_bit_cnt  <= '0;
            JOY_DATA   <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (w_load_low) begin
                r_state   <= LOAD;
                r_shift   <= w_load_word;
                r_bit_cnt <= '0;
                JOY_DATA  <= w_load_word[0];
            end else begin
                case (r_state)
                    IDLE: begin
                        JOY_DATA <= 1'b1;
                    end
                    LOAD: begin
                        r_state  <= SHIFT;
                        JOY_DATA <= r_shift[0];
                    end
                    SHIFT: begin
                        if (w_clk_rise) begin
                            r_shift   <= {1'b1, r_shift[FRAME_BITS-1:1]};
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                            if (r_bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                                r_state    <= DONE;
                                frame_done <= 1'b1;
                                JOY_DATA   <= 1'b1;
                            end else begin
                                JOY_DATA <= r_shift[1];
                            end
                        end
                    end
                    DONE: begin
                        JOY_DATA <= 1'b1;
                    end
                    default: begin
                        r_state  <= IDLE;
                        JOY_DATA <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Link watchdog: restarted by each synchronised load fall, drops after
    // TIMEOUT cycles without one.
    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            r_to_cnt    <= '0;
            link_active <= 1'b0;
        end else if (w_load_fall) begin
            r_to_cnt    <= '0;
            link_active <= 1'b1;
        end else if (r_to_cnt != TO_W'(TIMEOUT)) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
            if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
                link_active <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
